axis_data_unpadding: RTL and testbench
======================================

// Module: axis_data_unpadding
// PURPOSE
// - Receive-side counterpart of the output padding stage. Strips trailing all-ones padding
//   words from each 64-bit AXI-Stream packet and re-asserts tlast on the last real word.
// - Sits between the inbound DMA/datapath stream and frame consumers.
// - Reports the real-frame count of every completed packet.
// PARAMETERS
// - DATA_W  64           data width
// - PAD_VAL {DATA_W{1}}  padding word value (all ones)
// - CNT_W   32           width of frame counters
// PORTS
// - s_axis_aclk    in   1       single clock
// - s_axis_areset  in   1       asynchronous, active-high reset
// - s_axis_tready  out  1       input ready
// - s_axis_tdata   in   DATA_W  input data, padded stream
// - s_axis_tlast   in   1       input end of packet
// - s_axis_tvalid  in   1       input valid
// - m_axis_tready  in   1       output ready
// - m_axis_tdata   out  DATA_W  output data, real words only
// - m_axis_tlast   out  1       output end of packet, on last real word
// - m_axis_tvalid  out  1       output valid
// - frame_cnt      out  CNT_W   real words in last completed packet
// - frame_cnt_vld  out  1       one-cycle pulse when frame_cnt updates
// - pad_err        out  1       sticky: non-pad word seen after padding in same packet
// - pad_cnt        out  CNT_W   total pad words dropped (UNPAD_STATS_EN only)
// - pkt_cnt        out  CNT_W   total packets completed (UNPAD_STATS_EN only)
// BEHAVIOUR
// - Handshakes: s_hsk = s_axis_tvalid & s_axis_tready; m_hsk = m_axis_tvalid & m_axis_tready.
// - Word classification: is_pad = (s_axis_tdata == PAD_VAL).
// - One-word hold register (hold_data, hold_last). States are IDLE, HOLD and DROP.
// - Reset: IDLE, hold cleared, m_axis_tvalid=0, frame_cnt=0, frame_cnt_vld=0, pad_err=0,
//   stats=0. s_axis_tready=0 while reset is asserted.
// - IDLE: s_tready=1, m_tvalid=0.
//   - s_hsk & !is_pad: load hold, hold_last<=s_tlast, real_cnt<=1, go to HOLD.
//   - s_hsk & is_pad & s_tlast: packet with 0 real words; frame_cnt<=0, pulse vld, stay IDLE.
//   - s_hsk & is_pad & !s_tlast: go to DROP, real_cnt<=0.
// - HOLD: m_tdata=hold_data; s_tready = m_tready & !hold_last.
//   - m_tvalid = hold_last | s_tvalid; m_tlast = hold_last | (s_tvalid & is_pad).
//   - hold_last & m_hsk: go to IDLE, frame_cnt<=real_cnt, pulse vld.
//   - s_hsk & !is_pad: held word leaves with tlast=0; hold<=new word,
//     hold_last<=s_tlast, real_cnt+1.
//   - s_hsk & is_pad: held word leaves with tlast=1. If s_tlast, go to IDLE and pulse vld;
//     otherwise go to DROP.
// - DROP: s_tready=1, m_tvalid=0; all words are discarded.
//   - Non-pad word: set pad_err.
//   - s_tlast: go to IDLE, frame_cnt<=real_cnt, pulse vld.
// - Latency: each real word is output no earlier than the cycle after its acceptance.
//   Full throughput holds mid-packet, with a one-cycle bubble per packet end.
// - m_tdata/m_tlast stay stable while m_tvalid=1 and m_tready=0.
// - Counters saturate at all-ones and never wrap.
// - pad_err clears only on reset.
// - Asynchronous reset mid-packet drops the held word and returns to IDLE.
//   The following input is treated as a new packet.
// CONFIGURATION
// - UNPAD_STATS_EN defined: pad_cnt increments on every dropped pad word, including in IDLE;
//   pkt_cnt increments on each frame_cnt_vld. Both saturate.
// - UNPAD_STATS_EN undefined: pad_cnt and pkt_cnt are tied to 0 and the counter logic
//   is absent.
// TESTING
// - 3 real words D0..D2 then 2 pads, tlast on 2nd pad, m_tready=1
//   -> D0,D1,D2 out, tlast on D2; frame_cnt=3 with one vld pulse.
// - 4 real words, tlast on D3, no padding -> all 4 out, tlast on D3; frame_cnt=4.
// - Single pad word with tlast -> no output beat; frame_cnt=0, vld pulses;
//   pad_cnt=1 (STATS_EN).
// - Sequence D0, pad, D1, pad+tlast -> D0 out with tlast; D1 dropped; pad_err=1;
//   frame_cnt=1.
// - Random m_tready toggling over 100 packets of 1..8 real words plus 0..4 pads
//   -> output equals stripped input; no data change while stalled.
// - Assert reset while holding D5 mid-packet -> m_tvalid=0 next cycle; state IDLE;
//   next packet counted from 1.

Source files
------------

// File: rtl/axis_data_unpadding.sv
// Strips trailing all-ones padding words from AXI-Stream packets and moves tlast onto the last real word.
// Optional statistics counters (pad_cnt, pkt_cnt) are built only when UNPAD_STATS_EN is defined.
//
// state | meaning
// IDLE  | between packets, no word held; accepting the first word of a packet
// HOLD  | one real word held; it leaves once the next word shows whether it is last
// DROP  | padding reached; discarding the rest of the packet up to its tlast
module axis_data_unpadding #(
  parameter int                 DATA_W  = 64,
  parameter logic [DATA_W-1:0]  PAD_VAL = {DATA_W{1'b1}},
  parameter int                 CNT_W   = 32
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_areset,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              frame_cnt_vld,
  output logic              pad_err,
  output logic [CNT_W-1:0]  pad_cnt,
  output logic [CNT_W-1:0]  pkt_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  hold_data_q, hold_data_d;
  logic               hold_last_q, hold_last_d;
  logic [CNT_W-1:0]   real_cnt_q, real_cnt_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               frame_vld_q, frame_vld_d;
  logic               pad_err_q, pad_err_d;

  logic is_pad;
  logic s_hsk;
  logic m_hsk;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign is_pad = (s_axis_tdata == PAD_VAL);
  assign s_hsk  = s_axis_tvalid & s_axis_tready;
  assign m_hsk  = m_axis_tvalid & m_axis_tready;

  // State register
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_hsk) begin
          if (!is_pad)          state_d = S_HOLD;
          else if (!s_axis_tlast) state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (hold_last_q) begin
          if (m_hsk) state_d = S_IDLE;
        end else if (s_hsk && is_pad) begin
          state_d = s_axis_tlast ? S_IDLE : S_DROP;
        end
      end
      S_DROP: begin
        if (s_hsk && s_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; HOLD forwards the held word once its successor (or its own tlast) is known
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    unique case (state_q)
      S_IDLE: s_axis_tready = 1'b1;
      S_HOLD: begin
        s_axis_tready = m_axis_tready & ~hold_last_q;
        m_axis_tvalid = hold_last_q | s_axis_tvalid;
        m_axis_tlast  = hold_last_q | (s_axis_tvalid & is_pad);
      end
      S_DROP: s_axis_tready = 1'b1;
      default: s_axis_tready = 1'b0;
    endcase
    if (s_axis_areset) s_axis_tready = 1'b0;
  end

  assign m_axis_tdata  = hold_data_q;
  assign frame_cnt     = frame_cnt_q;
  assign frame_cnt_vld = frame_vld_q;
  assign pad_err       = pad_err_q;

  // Datapath next-state: hold register, per-packet real-word count, frame report, error flag
  always_comb begin
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    real_cnt_d  = real_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_vld_d = 1'b0;
    pad_err_d   = pad_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (s_hsk) begin
          if (!is_pad) begin
            hold_data_d = s_axis_tdata;
            hold_last_d = s_axis_tlast;
            real_cnt_d  = CNT_W'(1);
          end else begin
            real_cnt_d = '0;
            if (s_axis_tlast) begin
              frame_cnt_d = '0;
              frame_vld_d = 1'b1;
            end
          end
        end
      end
      S_HOLD: begin
        if (hold_last_q) begin
          if (m_hsk) begin
            frame_cnt_d = real_cnt_q;
            frame_vld_d = 1'b1;
          end
        end else if (s_hsk) begin
          if (!is_pad) begin
            hold_data_d = s_axis_tdata;
            hold_last_d = s_axis_tlast;
            real_cnt_d  = sat_inc(real_cnt_q);
          end else if (s_axis_tlast) begin
            frame_cnt_d = real_cnt_q;
            frame_vld_d = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (s_hsk) begin
          if (!is_pad) pad_err_d = 1'b1;
          if (s_axis_tlast) begin
            frame_cnt_d = real_cnt_q;
            frame_vld_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      real_cnt_q  <= '0;
      frame_cnt_q <= '0;
      frame_vld_q <= 1'b0;
      pad_err_q   <= 1'b0;
    end else begin
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      real_cnt_q  <= real_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      frame_vld_q <= frame_vld_d;
      pad_err_q   <= pad_err_d;
    end
  end

`ifdef UNPAD_STATS_EN
  logic [CNT_W-1:0] pad_cnt_q, pad_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  // Every accepted pad word is discarded, whatever the state
  always_comb begin
    pad_cnt_d = (s_hsk && is_pad) ? sat_inc(pad_cnt_q) : pad_cnt_q;
    pkt_cnt_d = frame_vld_d ? sat_inc(pkt_cnt_q) : pkt_cnt_q;
  end

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      pad_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      pad_cnt_q <= pad_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pad_cnt = pad_cnt_q;
  assign pkt_cnt = pkt_cnt_q;
`else
  assign pad_cnt = '0;
  assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_data_unpadding.sv
// Bench for axis_data_unpadding: directed and random packets checked against a packet-level model.
// Stats counters are checked against the model when UNPAD_STATS_EN is defined, else expected at zero.
module tb_axis_data_unpadding;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;
  localparam logic [DATA_W-1:0] PAD = {DATA_W{1'b1}};

  logic              clk = 1'b0;
  logic              rst;
  logic              s_tready;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tlast;
  logic              s_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tlast;
  logic              m_tvalid;
  logic [CNT_W-1:0]  frame_cnt;
  logic              frame_cnt_vld;
  logic              pad_err;
  logic [CNT_W-1:0]  pad_cnt;
  logic [CNT_W-1:0]  pkt_cnt;

  axis_data_unpadding #(.DATA_W(DATA_W), .PAD_VAL(PAD), .CNT_W(CNT_W)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .frame_cnt     (frame_cnt),
    .frame_cnt_vld (frame_cnt_vld),
    .pad_err       (pad_err),
    .pad_cnt       (pad_cnt),
    .pkt_cnt       (pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  int          tests = 0;
  int          fails = 0;
  beat_t       exp_q[$];
  int unsigned exp_fc[$];
  logic        exp_err = 1'b0;
  int unsigned exp_pad = 0;
  int unsigned exp_pkt = 0;
  bit          rdy_rand  = 1'b0;
  logic        rdy_fixed = 1'b1;
  bit          gap_en    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] v;
    v = {$urandom, $urandom};
    if (v == PAD) v[0] = 1'b0;
    return v;
  endfunction

  // Output-side ready: fixed or random, changed just after each rising edge
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Output monitor: beats, frame reports and stall stability
  initial begin
    beat_t             b;
    logic              stalled = 1'b0;
    logic [DATA_W-1:0] st_data = '0;
    logic              st_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_valid", m_tvalid, 1);
          check("stall_data", m_tdata, st_data);
          check("stall_last", m_tlast, st_last);
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
          else begin
            b = exp_q.pop_front();
            check("out_data", m_tdata, b.data);
            check("out_last", m_tlast, b.last);
          end
        end
        if (frame_cnt_vld) begin
          if (exp_fc.size() == 0) check("unexpected_vld", 1, 0);
          else check("frame_cnt", frame_cnt, exp_fc.pop_front());
        end
        stalled = m_tvalid & ~m_tready;
        st_data = m_tdata;
        st_last = m_tlast;
      end
    end
  end

  task automatic send_word(input logic [DATA_W-1:0] d, input logic l);
    int n = 0;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1 s_tvalid = 1'b0;
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 2000) begin
        check("s_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Model: output is the words before the first pad; later non-pad words flag an error
  task automatic send_pkt(input logic [DATA_W-1:0] w[$]);
    int first_pad = w.size();
    for (int i = 0; i < w.size(); i++)
      if (w[i] == PAD && first_pad == w.size()) first_pad = i;
    for (int i = 0; i < first_pad; i++)
      exp_q.push_back({(i == first_pad - 1), w[i]});
    exp_fc.push_back(first_pad);
    for (int i = 0; i < w.size(); i++) begin
      if (w[i] == PAD) exp_pad++;
      else if (i > first_pad) exp_err = 1'b1;
    end
    exp_pkt++;
    for (int i = 0; i < w.size(); i++) send_word(w[i], (i == w.size() - 1));
    @(posedge clk);
    #1 s_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || exp_fc.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() + exp_fc.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stats(input string tag);
`ifdef UNPAD_STATS_EN
    check({tag, "_pad_cnt"}, pad_cnt, exp_pad);
    check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
`else
    check({tag, "_pad_cnt"}, pad_cnt, 0);
    check({tag, "_pkt_cnt"}, pkt_cnt, 0);
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] w[$];
    logic [DATA_W-1:0] d5, d6;
    rst = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_vld", frame_cnt_vld, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_pad_err", pad_err, 0);
    check_stats("rst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_s_tready", s_tready, 1);

    // 3 real words + 2 pads
    w = {};
    for (int i = 0; i < 3; i++) w.push_back(rnd_word());
    w.push_back(PAD);
    w.push_back(PAD);
    send_pkt(w);
    drain();

    // 4 real words, no padding
    w = {};
    for (int i = 0; i < 4; i++) w.push_back(rnd_word());
    send_pkt(w);
    drain();

    // Lone pad with tlast
    w = {PAD};
    send_pkt(w);
    drain();
    check("pad_err_clean", pad_err, exp_err);
    check_stats("directed");

    // Real word after padding
    w = {rnd_word(), PAD, rnd_word(), PAD};
    send_pkt(w);
    drain();
    check("pad_err_set", pad_err, exp_err);

    // Random packets with random output stalls and input gaps
    rdy_rand = 1'b1;
    gap_en   = 1'b1;
    for (int p = 0; p < 100; p++) begin
      w = {};
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) w.push_back(rnd_word());
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) w.push_back(PAD);
      send_pkt(w);
    end
    drain();
    check("pad_err_sticky", pad_err, exp_err);
    check_stats("random");

    // Reset while a word is held and stalled mid-packet
    rdy_rand  = 1'b0;
    gap_en    = 1'b0;
    rdy_fixed = 1'b0;
    d5 = rnd_word();
    d6 = rnd_word();
    @(posedge clk);
    #1;
    s_tvalid = 1'b1;
    s_tdata  = d5;
    s_tlast  = 1'b0;
    @(negedge clk);
    check("d5_accept", s_tready, 1);
    @(posedge clk);
    #1 s_tdata = d6;
    @(negedge clk);
    check("hold_m_tvalid", m_tvalid, 1);
    check("hold_m_tdata", m_tdata, d5);
    check("hold_s_tready", s_tready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_s_tready", s_tready, 0);
    check("midrst_pad_err", pad_err, 0);
    exp_err = 1'b0;
    exp_pad = 0;
    exp_pkt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    rdy_rand = 1'b1;
    w = {rnd_word(), rnd_word(), rnd_word(), PAD};
    send_pkt(w);
    drain();
    check("post_rst_pad_err", pad_err, exp_err);
    check_stats("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
